// File: rtl/mult4x4_seq.sv
// Sequential 4x4 unsigned multiplier built around one external 2x2 tile.
// Four partial products, one per cycle, are shifted and summed into an 8-bit accumulator.
//
// state | meaning
// IDLE  | waiting for start; tile operands forced to zero
// CALC  | stepping through the four partial products (step 0..3)
module mult4x4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [1:0] mul_a,
  output logic [1:0] mul_b,
  input  logic [3:0] mul_f
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t     state, state_nxt;
  logic [1:0] step;
  logic [3:0] ra, rb;
  logic [7:0] acc;
  logic [2:0] shamt;
  logic [7:0] pp;
  logic       last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // step[0] selects the high half of ra, step[1] the high half of rb; shift is 0,2,2,4
  always_comb begin
    mul_a = 2'd0;
    mul_b = 2'd0;
    shamt = 3'd0;
    if (state == CALC) begin
      mul_a = step[0] ? ra[3:2] : ra[1:0];
      mul_b = step[1] ? rb[3:2] : rb[1:0];
      shamt = {step[0] & step[1], step[0] ^ step[1], 1'b0};
    end
  end

  assign pp        = {4'd0, mul_f} << shamt;
  assign last_step = (step == 2'd3);
  assign busy      = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step    <= 2'd0;
      ra      <= 4'd0;
      rb      <= 4'd0;
      acc     <= 8'd0;
      product <= 8'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra   <= a;
            rb   <= b;
            acc  <= 8'd0;
            step <= 2'd0;
          end
        end
        CALC: begin
          acc  <= acc + pp;
          step <= step + 2'd1;
          if (last_step) begin
            product <= acc + pp;
            done    <= 1'b1;
            step    <= 2'd0;
          end
        end
        default: step <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4x4_seq.sv
// Self-checking bench for mult4x4_seq: behavioural 2x2 tile, vector table and
// a product scoreboard, plus back-to-back and mid-operation reset sequences.
module tb_mult4x4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done;
  logic [7:0] product;
  logic [1:0] mul_a, mul_b;
  logic [3:0] mul_f;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] sb[$];

  mult4x4_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .mul_a(mul_a), .mul_b(mul_b), .mul_f(mul_f)
  );

  // external 2x2 tile
  assign mul_f = {2'd0, mul_a} * {2'd0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] exp_p;
    bit         mutate;
    bit         poke;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result();
    logic [7:0] e;
    chk("done_hi", done, 1);
    chk("busy_in_done", busy, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("product", product, e);
    end
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] exp_p, input bit mutate, input bit poke);
    logic [1:0] ema, emb;
    logic [7:0] held;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(exp_p);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ema = (k == 1 || k == 3) ? x[3:2] : x[1:0];
      emb = (k >= 2)           ? y[3:2] : y[1:0];
      chk("busy", busy, 1);
      chk("done_lo_calc", done, 0);
      chk("mul_a", mul_a, ema);
      chk("mul_b", mul_b, emb);
      if (mutate) begin a = ~x; b = ~y; end
      if (poke && k == 1) start = 1'b1;
      if (poke && k == 2) start = 1'b0;
      @(negedge clk);
    end
    check_result();
    held = product;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy, 0);
    chk("product_hold", product, held);
  endtask

  initial begin
    int t0, t1, t2;
    bit seen_done;

    vecs[0] = '{4'd0,  4'd0,  8'h00, 1'b0, 1'b0};
    vecs[1] = '{4'd15, 4'd15, 8'hE1, 1'b0, 1'b0};
    vecs[2] = '{4'd6,  4'd9,  8'h36, 1'b1, 1'b0};
    vecs[3] = '{4'd6,  4'd9,  8'h36, 1'b0, 1'b1};
    vecs[4] = '{4'd1,  4'd1,  8'h01, 1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'd1,  8'h0F, 1'b0, 1'b0};
    vecs[6] = '{4'd8,  4'd8,  8'h40, 1'b0, 1'b0};
    vecs[7] = '{4'd12, 4'd13, 8'h9C, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].mutate, vecs[i].poke);

    // start held high across two operations, new operands applied in the done cycle
    @(negedge clk);
    a = 4'd5; b = 4'd7; start = 1'b1;
    sb.push_back(8'h23);
    t0 = cyc;
    wait_done(8);
    check_result();
    t1 = cyc;
    a = 4'd3; b = 4'd12;
    sb.push_back(8'h24);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_lo", done, 0);
    wait_done(8);
    check_result();
    t2 = cyc;
    chk("b2b_first_latency", t1 - t0, 5);
    chk("b2b_interval", t2 - t1, 5);
    @(negedge clk);
    chk("b2b_done_drop", done, 0);

    // reset during step2 aborts without a done pulse
    @(negedge clk);
    a = 4'd10; b = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_step2_mul_a", mul_a, 2'd2);
    chk("pre_rst_product", product, 8'h24);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_idle", busy, 0);
    run_op(4'd10, 4'd11, 8'h6E, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
